// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types.
// Holds the data width, requester ID encodings, arbitration modes and the
// result-slot state type used by the shared-adder arbiter.
package cpu_pkg;

    localparam int DATA_W = 4;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Slot state is carried directly by rsp_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/rca_arbiter_if.sv
// Request/response bundle between the two adder requesters, the consumer
// and the shared-adder arbiter.
//   req0/a0/b0, req1/a1/b1 : requests with operands (held until granted)
//   gnt0/gnt1              : combinational accept for each requester
//   rsp_valid/rsp_id/rsp_sum : one-entry result slot
//   rsp_ready              : consumer takes the result this cycle
// master = requesters + consumer side, slave = arbiter side.
interface rca_arbiter_if;
    import cpu_pkg::*;

    logic              req0;
    logic [DATA_W-1:0] a0;
    logic [DATA_W-1:0] b0;
    logic              gnt0;
    logic              req1;
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic              gnt1;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_sum;
    logic              rsp_ready;

    modport master (
        output req0, a0, b0, req1, a1, b1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/rca_arbiter_rca.sv
// Shared ripple-carry adder, DATA_W bits, carry-out discarded.
//   a, b : operands
//   sum  : (a + b) mod 2**DATA_W
module rca
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    // Only the carries feeding a sum bit are built; the final carry-out
    // has no consumer.
    logic [DATA_W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < DATA_W - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/rca_arbiter.sv
// Two-requester arbiter in front of the shared ripple-carry adder.
// Grants at most one request per cycle, feeds the winner's operands to the
// adder and registers the sum with the winner's ID into a one-entry slot
// that honours consumer backpressure.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rca_arbiter_if.slave (requests, grants, result slot)
//   PRIO_MODE: PRIO_RR alternates on contention, PRIO_FIXED favours req0
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | slot free, rsp_valid = 0
// ST_FULL  | slot holds a sum for rsp_id, rsp_valid = 1
module rca_arbiter
    import cpu_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic         clk,
    input  logic         rst,
    rca_arbiter_if.slave bus
);

    slot_state_t       state_q;
    slot_state_t       state_d;
    logic              last_id_q;
    logic              id_q;
    logic [DATA_W-1:0] sum_q;

    logic              free;
    logic              pick1;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] add_sum;

    always_comb begin
        free    = 1'b0;
        pick1   = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        accept  = 1'b0;
        state_d = state_q;

        // A draining consumer frees the slot in the same cycle, so a new
        // result can replace it without a bubble.
        free  = (state_q == ST_EMPTY) || bus.rsp_ready;
        pick1 = bus.req1 &&
                (!bus.req0 || (PRIO_MODE == PRIO_RR && last_id_q == ID_REQ0));

        // Reset suppresses grants so no accept lands during reset.
        gnt0   = !rst && free && bus.req0 && !pick1;
        gnt1   = !rst && free && pick1;
        accept = gnt0 || gnt1;

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && bus.rsp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Idle cycles leave the mux on requester 0; the value is unused.
    assign op_a = gnt1 ? bus.a1 : bus.a0;
    assign op_b = gnt1 ? bus.b1 : bus.b0;

    rca u_rca (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            sum_q     <= '0;
            id_q      <= ID_REQ0;
            last_id_q <= ID_REQ1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sum_q     <= add_sum;
                id_q      <= gnt1 ? ID_REQ1 : ID_REQ0;
                last_id_q <= gnt1 ? ID_REQ1 : ID_REQ0;
            end
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;

endmodule

// File: tb/tb_rca_arbiter.sv
// Self-checking bench for rca_arbiter: one round-robin and one fixed-priority
// instance driven by identical stimulus, each compared against its own
// slot-level reference model (directed scenarios, then random traffic).
module tb_rca_arbiter;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    logic d_req0, d_req1, d_ready;
    logic [3:0] d_a0, d_b0, d_a1, d_b1;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = round-robin, 1 = fixed priority.
    int m_v[2];
    int m_id[2];
    int m_sum[2];
    int m_last[2];
    int eg[2];

    rca_arbiter_if bus_rr ();
    rca_arbiter_if bus_fx ();

    assign bus_rr.req0 = d_req0;  assign bus_fx.req0 = d_req0;
    assign bus_rr.a0   = d_a0;    assign bus_fx.a0   = d_a0;
    assign bus_rr.b0   = d_b0;    assign bus_fx.b0   = d_b0;
    assign bus_rr.req1 = d_req1;  assign bus_fx.req1 = d_req1;
    assign bus_rr.a1   = d_a1;    assign bus_fx.a1   = d_a1;
    assign bus_rr.b1   = d_b1;    assign bus_fx.b1   = d_b1;
    assign bus_rr.rsp_ready = d_ready;
    assign bus_fx.rsp_ready = d_ready;

    rca_arbiter #(.PRIO_MODE(PRIO_RR)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr)
    );

    rca_arbiter #(.PRIO_MODE(PRIO_FIXED)) u_dut_fx (
        .clk (clk),
        .rst (rst),
        .bus (bus_fx)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_grant(int m);
        if (rst) return -1;
        if (m_v[m] != 0 && !d_ready) return -1;
        if (d_req0 && d_req1) return (m == 1) ? 0 : 1 - m_last[m];
        if (d_req0) return 0;
        if (d_req1) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_v[m] = 0; m_id[m] = 0; m_sum[m] = 0; m_last[m] = 1; eg[m] = -1;
        end
    endtask

    task automatic step(input logic r, input logic q0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic q1, input logic [3:0] a1, input logic [3:0] b1, input logic rdy);
        @(negedge clk);
        rst = r; d_req0 = q0; d_a0 = a0; d_b0 = b0;
        d_req1 = q1; d_a1 = a1; d_b1 = b1; d_ready = rdy;
        #1;
        for (int m = 0; m < 2; m++) begin
            eg[m] = exp_grant(m);
            chk($sformatf("gnt0[m%0d]", m), (m == 0) ? bus_rr.gnt0 : bus_fx.gnt0, (eg[m] == 0) ? 1 : 0);
            chk($sformatf("gnt1[m%0d]", m), (m == 0) ? bus_rr.gnt1 : bus_fx.gnt1, (eg[m] == 1) ? 1 : 0);
            chk($sformatf("rsp_valid[m%0d]", m), (m == 0) ? bus_rr.rsp_valid : bus_fx.rsp_valid, m_v[m]);
            chk($sformatf("rsp_id[m%0d]", m), (m == 0) ? bus_rr.rsp_id : bus_fx.rsp_id, m_id[m]);
            chk($sformatf("rsp_sum[m%0d]", m), (m == 0) ? bus_rr.rsp_sum : bus_fx.rsp_sum, m_sum[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                m_v[m] = 0; m_id[m] = 0; m_sum[m] = 0; m_last[m] = 1;
            end else if (eg[m] == 0) begin
                m_v[m] = 1; m_id[m] = 0; m_last[m] = 0; m_sum[m] = (int'(a0) + int'(b0)) % 16;
            end else if (eg[m] == 1) begin
                m_v[m] = 1; m_id[m] = 1; m_last[m] = 1; m_sum[m] = (int'(a1) + int'(b1)) % 16;
            end else if (m_v[m] != 0 && rdy) begin
                m_v[m] = 0;
            end
        end
    endtask

    initial begin
        logic       n_rst, n_q0, n_q1, n_rdy;
        logic [3:0] n_a0, n_b0, n_a1, n_b1;

        rst = 1'b1; d_req0 = 0; d_req1 = 0; d_ready = 0;
        d_a0 = 0; d_b0 = 0; d_a1 = 0; d_b1 = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Single request after reset, then wrap-around sums.
        step(0, 1, 4'd3, 4'd4, 0, 4'd0, 4'd0, 1);
        step(0, 0, 4'd0, 4'd0, 1, 4'hF, 4'h1, 1);
        step(0, 0, 4'd0, 4'd0, 1, 4'd9, 4'd9, 1);
        // Continuous contention.
        repeat (4) step(0, 1, 4'd2, 4'd5, 1, 4'd6, 4'd7, 1);
        // Backpressure then release with no bubble.
        repeat (3) step(0, 0, 4'd0, 4'd0, 1, 4'd4, 4'd4, 0);
        step(0, 0, 4'd0, 4'd0, 1, 4'd4, 4'd4, 1);
        step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0);
        // Reset while the slot is full and req0 is pending.
        step(1, 1, 4'd5, 4'd5, 0, 4'd0, 4'd0, 0);
        step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0);
        // Request withdrawal during backpressure.
        step(0, 1, 4'd1, 4'd1, 0, 4'd0, 4'd0, 0);
        repeat (2) step(0, 0, 4'd0, 4'd0, 1, 4'd7, 4'd7, 0);
        step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
        step(0, 0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);

        // Random traffic; operands held while a request is still pending.
        for (int i = 0; i < 400; i++) begin
            n_rst = ($urandom_range(0, 49) == 0);
            n_rdy = ($urandom_range(0, 3) != 0);
            if (d_req0 && !(eg[0] == 0 && eg[1] == 0)) begin
                n_q0 = ($urandom_range(0, 7) != 0);
                n_a0 = d_a0; n_b0 = d_b0;
            end else begin
                n_q0 = 1'($urandom_range(0, 1));
                n_a0 = 4'($urandom_range(0, 15)); n_b0 = 4'($urandom_range(0, 15));
            end
            if (d_req1 && !(eg[0] == 1 && eg[1] == 1)) begin
                n_q1 = ($urandom_range(0, 7) != 0);
                n_a1 = d_a1; n_b1 = d_b1;
            end else begin
                n_q1 = 1'($urandom_range(0, 1));
                n_a1 = 4'($urandom_range(0, 15)); n_b1 = 4'($urandom_range(0, 15));
            end
            step(n_rst, n_q0, n_a0, n_b0, n_q1, n_a1, n_b1, n_rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
